// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a byte-wide memory between fetch and data ports, serialising big-endian words.
// Define MEM_ARB_STATS_EN to add per-port wait-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int IF_STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_size,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       if_wait_cnt,
    output logic [15:0]       dm_wait_cnt
`endif
);
    localparam int SW = $clog2(IF_STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(IF_STARVE_MAX);
    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] beat, last;
    logic [ADDR_W-1:0] base;
    logic [SW-1:0] starve;
    logic we, is_if, grant_if, grant_dm, last_beat, xfer;
    logic [31:0] sh, word_in;
    logic unused;
    assign unused = ^{if_addr[31:ADDR_W], if_addr[1:0], dm_addr[31:ADDR_W]};
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        grant_dm  = dm_req && !(if_req && starve == SMAX);
        grant_if  = if_req && !grant_dm;
        last_beat = beat == last;
        xfer      = state == IF_XFER || state == DM_XFER;
        state_nx  = state;
        case (state)
            IDLE:             state_nx = grant_dm ? DM_XFER : grant_if ? IF_XFER : IDLE;
            IF_XFER, DM_XFER: state_nx = last_beat ? DONE : state;
            default:          state_nx = IDLE;
        endcase
    end
    assign mem_addr  = xfer ? base + ADDR_W'(beat) : '0;
    assign mem_we    = state == DM_XFER && we;
    assign mem_wdata = mem_we ? sh[31:24] : 8'h00;
    assign if_ready  = state == DONE && is_if;
    assign dm_ready  = state == DONE && !is_if;
    // One shift register serves both directions: writes shift bytes out the top, reads shift them in at the bottom.
    assign word_in = last == 2'd0 ? {24'h0, mem_rdata} : {sh[23:0], mem_rdata};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            beat     <= '0;
            last     <= '0;
            base     <= '0;
            starve   <= '0;
            we       <= 1'b0;
            is_if    <= 1'b0;
            sh       <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (state == IDLE) begin
            beat <= '0;
            if (grant_dm) begin
                base  <= dm_size ? {dm_addr[ADDR_W-1:2], 2'b00} : dm_addr[ADDR_W-1:0];
                last  <= dm_size ? 2'd3 : 2'd0;
                we    <= dm_we;
                sh    <= dm_size ? dm_wdata : {dm_wdata[7:0], 24'h0};
                is_if <= 1'b0;
                if (if_req) starve <= starve + SW'(1);
            end else if (grant_if) begin
                base   <= {if_addr[ADDR_W-1:2], 2'b00};
                last   <= 2'd3;
                we     <= 1'b0;
                is_if  <= 1'b1;
                starve <= '0;
            end
        end else if (xfer) begin
            beat <= beat + 2'd1;
            sh   <= {sh[23:0], we ? 8'h00 : mem_rdata};
            if (last_beat && !we) begin
                if (is_if) if_rdata <= word_in;
                else dm_rdata <= word_in;
            end
        end
`ifdef MEM_ARB_STATS_EN
    logic if_act, dm_act;
    assign if_act = state == IDLE ? grant_if : is_if;
    assign dm_act = state == IDLE ? grant_dm : !is_if;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            if_wait_cnt <= '0;
            dm_wait_cnt <= '0;
        end else begin
            if (if_req && !if_act && if_wait_cnt != 16'hFFFF) if_wait_cnt <= if_wait_cnt + 16'd1;
            if (dm_req && !dm_act && dm_wait_cnt != 16'hFFFF) dm_wait_cnt <= dm_wait_cnt + 16'd1;
        end
`endif
endmodule
